serial_rx: RTL and testbench
============================

# serial_rx

UART receiver with 8-N-1 framing. It converts the asynchronous serial input pad (already registered by the pad I/O cell) into parallel bytes. Bytes are presented to the core through a one-entry holding register with a valid/ready handshake, and sticky framing-error and overrun flags report line problems. It is the receive-side counterpart of the core's serial transmitter and sits between the RX pad and the CPU's byte-input logic.

## Interface
- `CLK_FREQ`, default 48_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 115_200: line rate in bit/s.
- `BAUD_CNT` (localparam) = CLK_FREQ / BAUD_RATE, using integer division.
- `HALF_CNT` (localparam) = BAUD_CNT / 2.

Ports:
- `i_clk`  in  1  system clock; all state changes on its rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_rx`  in  1  serial line; idles high.
- `o_data`  out  8  received byte; valid while `o_valid`=1.
- `o_valid`  out  1  holding register full.
- `i_ready`  in  1  consumer accepts byte when `o_valid & i_ready`.
- `o_error`  out  1  sticky framing error.
- `o_overrun`  out  1  sticky overrun.
- `i_clr`  in  1  single-cycle pulse; clears `o_error` and `o_overrun`.

## Operation
- `i_rx` passes through a 2-FF synchronizer whose flops reset to 1. All decisions use the synchronized value `rx_s`.
- A down-counter `timer` generates events. An event ("tick") occurs in the cycle where `timer`==0. After a load with value N−1, the tick occurs N cycles later.
- State machine:
  - **IDLE**: when `rx_s`=0, load `timer`=HALF_CNT−1 and go to START.
  - **START**: on tick:
    - if `rx_s`=1, treat it as a glitch and return to IDLE; nothing is recorded.
    - otherwise load BAUD_CNT−1, set `bit_idx`=0, and go to DATA.
  - **DATA**: on tick, shift `rx_s` into the MSB of `shift` (right shift, so the byte is LSB-first) and reload BAUD_CNT−1. After the shift where `bit_idx`=7, go to STOP; otherwise increment `bit_idx`.
  - **STOP**: on tick:
    - if `rx_s`=1, deliver `shift` and go to IDLE.
    - if `rx_s`=0, set `o_error`, discard the byte, and go to WAIT_HIGH.
  - **WAIT_HIGH**: remain until `rx_s`=1, then go to IDLE. This prevents a break condition from being parsed as repeated frames.
- Delivery:
  - If `o_valid`=0, or `i_ready`=1 in the same cycle: `o_data`←`shift` and `o_valid`←1.
  - Otherwise: set `o_overrun`, drop the new byte, and leave `o_data` unchanged.
- Consumption: `o_valid & i_ready` with no delivery in that cycle gives `o_valid`←0 on the next edge. `o_data` holds its last value.
- `i_clr` clears both flags. If a flag is set in the same cycle as `i_clr`, the set wins.
- `i_ready` is ignored while `o_valid`=0.

## Timing
- Reset values:
  - `o_data`=0x00, `o_valid`=0, `o_error`=0, `o_overrun`=0.
  - state IDLE, `timer`=0, `bit_idx`=0, `shift`=0x00, synchronizer=2'b11.
- Reset asserted mid-frame aborts the frame immediately with no partial byte and no flag. After release, a new start requires a fresh low level on `rx_s`.
- Sample points, measured in cycles after the edge where IDLE sees `rx_s`=0:
  - start bit: HALF_CNT
  - data bit k: HALF_CNT + (k+1)·BAUD_CNT
  - stop bit: HALF_CNT + 9·BAUD_CNT
- `o_valid` rises, or `o_error`/`o_overrun` sets, on the edge ending the stop-tick cycle.
- Pin-to-detection latency is 2 cycles (synchronizer) plus the pad register.
- Throughput: a new start can be detected in the cycle after STOP→IDLE, so back-to-back frames with a one-bit stop are received without loss.
- Tolerance: the design must accept ±2% baud mismatch at BAUD_CNT ≥ 16.

## Structure
- The `CLK_FREQ`/`BAUD_RATE`→`BAUD_CNT` derivation and the 8-N-1 frame constants (data bits = 8, stop bits = 1) go in a shared include, `serial_defs.vh`, which the transmitter also uses.
- State encoding is local to this module (5 states, 3-bit localparams).
- One natural sub-module is `sync_2ff`, a 2-flop synchronizer with a reset value parameter (here 1). Everything else stays flat.

## Test plan
All scenarios use `CLK_FREQ`=12_000_000, `BAUD_RATE`=115_200, so BAUD_CNT=104 and HALF_CNT=52.

1. Send 0x55 with `i_ready`=1 → `o_valid` high for exactly 1 cycle with `o_data`=0x55, at 2+52+936 cycles after the pin falls (±1). No flags set.
2. Send 0xA3 then 0x0F back-to-back with `i_ready`=0 → `o_data` stays 0xA3 and `o_overrun`=1. Then pulse `i_clr` → `o_overrun`=0. Then `i_ready`=1 → `o_valid` drops.
3. Hold the line low for 20 bit-times, then send 0x41 → `o_error`=1, no `o_valid` during the low period, one start accepted only after the line returns high, then `o_data`=0x41.
4. Drive `i_rx` low for 30 cycles, then high → START rejects it as a glitch: no `o_valid`, no flags, back in IDLE. A following 0xC7 is received correctly.
5. Assert `i_rst` during bit 4 of 0xFF → all outputs at reset values. The next frame, 0x3C, is received with no flags.
6. Drive `i_ready`=1 on the exact cycle of the stop tick while holding 0x11, with 0x22 incoming → `o_valid` stays 1, `o_data`=0x22, `o_overrun`=0.

Source files
------------

// File: rtl/serial_rx_pkg.sv
// rtl/serial_rx_pkg.sv - shared 8-N-1 frame constants, baud derivation and receiver state type
package serial_rx_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_t;

  // Clock cycles per bit; integer division, matching the transmitter
  function automatic int calc_baud_cnt(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/serial_rx_sync_2ff.sv
// rtl/serial_rx_sync_2ff.sv - two-flop synchronizer with configurable reset value
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= {2{RESET_VAL}};
    else       r_sync <= {r_sync[0], i_d};
  end

  assign o_q = r_sync[1];

endmodule

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - 8-N-1 UART receiver with one-entry holding register and sticky flags
module serial_rx
  import serial_rx_pkg::*;
#(
  parameter int CLK_FREQ  = 48_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_error,
  output logic       o_overrun,
  input  logic       i_clr
);

  localparam int BAUD_CNT = calc_baud_cnt(CLK_FREQ, BAUD_RATE);
  localparam int HALF_CNT = BAUD_CNT / 2;
  localparam int TW       = (BAUD_CNT > 2) ? $clog2(BAUD_CNT) : 1;
  localparam logic [TW-1:0] BAUD_LOAD = TW'(BAUD_CNT - 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(HALF_CNT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  logic                 w_rx_s;
  rx_state_t            r_state, w_state_nx;
  logic [TW-1:0]        r_timer, w_timer_nx;
  logic [2:0]           r_bit_idx, w_bit_idx_nx;
  logic [DATA_BITS-1:0] r_shift, w_shift_nx;
  logic                 w_tick;
  logic                 w_deliver;
  logic                 w_frame_err;
  logic [7:0]           r_data;
  logic                 r_valid;
  logic                 r_error;
  logic                 r_overrun;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (w_rx_s)
  );

  assign w_tick = (r_timer == '0);

  // Next-state, timer, bit counter and shift register; frame outcome strobes
  always_comb begin
    w_state_nx   = r_state;
    w_timer_nx   = w_tick ? r_timer : r_timer - 1'b1;
    w_bit_idx_nx = r_bit_idx;
    w_shift_nx   = r_shift;
    w_deliver    = 1'b0;
    w_frame_err  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) begin
          w_timer_nx = HALF_LOAD;
          w_state_nx = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (w_rx_s) begin
            w_state_nx = ST_IDLE;
          end else begin
            w_timer_nx   = BAUD_LOAD;
            w_bit_idx_nx = 3'd0;
            w_state_nx   = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_shift_nx = {w_rx_s, r_shift[DATA_BITS-1:1]};
          w_timer_nx = BAUD_LOAD;
          if (r_bit_idx == LAST_BIT) w_state_nx = ST_STOP;
          else                       w_bit_idx_nx = r_bit_idx + 3'd1;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (w_rx_s) begin
            w_deliver  = 1'b1;
            w_state_nx = ST_IDLE;
          end else begin
            w_frame_err = 1'b1;
            w_state_nx  = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (w_rx_s) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Receiver state registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_timer   <= w_timer_nx;
      r_bit_idx <= w_bit_idx_nx;
      r_shift   <= w_shift_nx;
    end
  end

  // Holding register handshake and sticky flags; a same-cycle set beats i_clr
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_error   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_deliver) begin
        if (!r_valid || i_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
      r_error   <= (r_error & ~i_clr) | w_frame_err;
      r_overrun <= (r_overrun & ~i_clr) | (w_deliver & r_valid & ~i_ready);
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_error   = r_error;
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_serial_rx.sv
// tb/tb_serial_rx.sv - scoreboard bench for serial_rx with directed and randomized frames
module tb_serial_rx;

  localparam int BC = 104;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       err;
  logic       ovr;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         valid_cycles = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  serial_rx #(.CLK_FREQ(12_000_000), .BAUD_RATE(115_200)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_rx      (rx),
    .o_data    (data),
    .o_valid   (valid),
    .i_ready   (ready),
    .o_error   (err),
    .o_overrun (ovr),
    .i_clr     (clr)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted byte must be the oldest expected one
  always @(negedge clk) begin
    if (valid) valid_cycles++;
    if (!rst && valid && ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard: unexpected byte 0x%0h, expected none", data);
      end else begin
        check("scoreboard_data", int'(data), int'(exp_q.pop_front()));
      end
    end
  end

  // Inputs change 2 time units after a rising edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] b, input int period, input logic stop_val);
    rx = 1'b0;
    repeat (period) step();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (period) step();
    end
    rx = stop_val;
    repeat (period) step();
    rx = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 3000 && exp_q.size() != 0; k++) step();
    check(name, exp_q.size(), 0);
  endtask

  int         lat;
  int         hi;
  logic       err_model;
  logic [7:0] b;
  int         per;
  logic       good;

  initial begin
    // Reset values
    repeat (3) step();
    check("rst_data", int'(data), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_error", int'(err), 0);
    check("rst_overrun", int'(ovr), 0);
    rst = 1'b0;
    repeat (5) step();

    // 1: single byte, latency and one-cycle valid
    ready = 1'b1;
    exp_q.push_back(8'h55);
    fork
      send_frame(8'h55, BC, 1'b1);
      begin
        int c0;
        c0 = cyc;
        while (!valid && (cyc - c0) < 1500) @(negedge clk);
        lat = cyc - c0;
        hi = 0;
        while (valid && hi < 10) begin
          hi++;
          @(negedge clk);
        end
      end
    join
    check("t1_latency_in_window", int'(lat >= 989 && lat <= 992), 1);
    check("t1_valid_cycles", hi, 1);
    drain("t1_drain");
    check("t1_error", int'(err), 0);
    check("t1_overrun", int'(ovr), 0);

    // 2: overrun while holding, then clear and consume
    ready = 1'b0;
    exp_q.push_back(8'hA3);
    send_frame(8'hA3, BC, 1'b1);
    send_frame(8'h0F, BC, 1'b1);
    repeat (10) step();
    check("t2_valid", int'(valid), 1);
    check("t2_data_held", int'(data), 8'hA3);
    check("t2_overrun", int'(ovr), 1);
    check("t2_error", int'(err), 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    check("t2_overrun_cleared", int'(ovr), 0);
    ready = 1'b1;
    repeat (2) step();
    check("t2_valid_dropped", int'(valid), 0);
    check("t2_queue", exp_q.size(), 0);

    // 3: break condition then a normal frame
    valid_cycles = 0;
    rx = 1'b0;
    repeat (20 * BC) step();
    check("t3_no_valid_in_break", valid_cycles, 0);
    check("t3_error", int'(err), 1);
    rx = 1'b1;
    repeat (2 * BC) step();
    check("t3_no_valid_after_break", valid_cycles, 0);
    exp_q.push_back(8'h41);
    send_frame(8'h41, BC, 1'b1);
    drain("t3_drain");
    check("t3_error_sticky", int'(err), 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    check("t3_error_cleared", int'(err), 0);

    // 4: short low glitch rejected
    valid_cycles = 0;
    rx = 1'b0;
    repeat (30) step();
    rx = 1'b1;
    repeat (100) step();
    check("t4_no_valid", valid_cycles, 0);
    check("t4_error", int'(err), 0);
    check("t4_overrun", int'(ovr), 0);
    exp_q.push_back(8'hC7);
    send_frame(8'hC7, BC, 1'b1);
    drain("t4_drain");

    // 5: reset during bit 4 of 0xFF
    rx = 1'b0;
    repeat (BC) step();
    rx = 1'b1;
    repeat (4 * BC + BC / 2) step();
    rst = 1'b1;
    repeat (3) step();
    check("t5_data", int'(data), 0);
    check("t5_valid", int'(valid), 0);
    check("t5_error", int'(err), 0);
    check("t5_overrun", int'(ovr), 0);
    rst = 1'b0;
    repeat (5 * BC) step();
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, BC, 1'b1);
    drain("t5_drain");
    check("t5_error_after", int'(err), 0);
    check("t5_overrun_after", int'(ovr), 0);

    // 6: ready asserted exactly in the stop-tick cycle
    ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, BC, 1'b1);
    repeat (20) step();
    exp_q.push_back(8'h22);
    fork
      send_frame(8'h22, BC, 1'b1);
      begin
        repeat (990) step();
        ready = 1'b1;
        step();
        ready = 1'b0;
      end
    join
    repeat (5) step();
    check("t6_valid", int'(valid), 1);
    check("t6_data", int'(data), 8'h22);
    check("t6_overrun", int'(ovr), 0);
    check("t6_queue_left", exp_q.size(), 1);
    ready = 1'b1;
    drain("t6_drain");

    // Random frames with baud mismatch, glitches and bad stop bits
    err_model = 1'b0;
    for (int f = 0; f < 12; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        rx = 1'b0;
        repeat ($urandom_range(3, 40)) step();
        rx = 1'b1;
        repeat (80) step();
      end
      b    = 8'($urandom);
      per  = int'($urandom_range(102, 106));
      good = ($urandom_range(0, 5) != 0);
      if (good) exp_q.push_back(b);
      else      err_model = 1'b1;
      send_frame(b, per, good);
      repeat (good ? $urandom_range(0, 20) : $urandom_range(20, 40)) step();
    end
    drain("rand_drain");
    repeat (20) step();
    check("rand_error", int'(err), int'(err_model));
    check("rand_overrun", int'(ovr), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
